// File: rtl/vram_pattern_buffer.sv
// vram_pattern_buffer: 3-bit-per-pixel frame store with a built-in pattern
// fill engine (bands / bars / checker / clear), one host write port and one
// registered read port. Reset restarts a band fill without clearing memory.
module vram_pattern_buffer #(
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 7,
    parameter int NUM_ROWS = 96
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init_start,
    input  logic [1:0]                   init_mode,
    output logic                         init_busy,
    input  logic                         wr_en,
    input  logic [ROW_BITS+COL_BITS-1:0] wr_addr,
    input  logic [2:0]                   wr_data,
    input  logic                         rd_en,
    input  logic [ROW_BITS+COL_BITS-1:0] rd_addr,
    output logic [2:0]                   rd_data,
    output logic                         rd_valid
);

    localparam int NPIX = NUM_ROWS * (1 << COL_BITS);
    localparam int AW   = ROW_BITS + COL_BITS;

    // Band boundaries, one bit wider than the row field so NUM_ROWS may
    // equal 2^ROW_BITS without truncating to zero.
    localparam logic [ROW_BITS:0] ROW_LIMIT = (ROW_BITS+1)'(NUM_ROWS);
    localparam logic [ROW_BITS:0] BAND_1    = (ROW_BITS+1)'(NUM_ROWS / 4);
    localparam logic [ROW_BITS:0] BAND_2    = (ROW_BITS+1)'(NUM_ROWS / 2);
    localparam logic [ROW_BITS:0] BAND_3    = (ROW_BITS+1)'((3 * NUM_ROWS) / 4);
    localparam logic [AW-1:0]     LAST_PIX  = AW'(NPIX - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Pixel value of the selected test pattern at (row, col).
    function automatic logic [2:0] pattern_pixel(
        input logic [1:0]          mode,
        input logic [ROW_BITS-1:0] row,
        input logic [COL_BITS-1:0] col
    );
        logic [2:0] pix;
        case (mode)
            2'd0: begin
                if ({1'b0, row} < BAND_1) begin
                    pix = 3'b100;
                end else if ({1'b0, row} < BAND_2) begin
                    pix = 3'b010;
                end else if ({1'b0, row} < BAND_3) begin
                    pix = 3'b001;
                end else begin
                    pix = 3'b111;
                end
            end
            2'd1:    pix = col[2:0];
            2'd2:    pix = (row[0] ^ col[0]) ? 3'b111 : 3'b000;
            2'd3:    pix = 3'b000;
            default: pix = 3'b000;
        endcase
        return pix;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        mode_r;
    logic [1:0]        mode_nxt_s;
    logic [AW-1:0]     cnt_r;
    logic [AW-1:0]     cnt_nxt_s;
    logic              busy_r;

    logic              mem_we_s;
    logic [AW-1:0]     mem_waddr_s;
    logic [2:0]        mem_wdata_s;
    logic              wr_row_ok_s;
    logic              rd_row_ok_s;
    logic [2:0]        rd_data_r;
    logic              rd_valid_r;

    logic [2:0]        mem_r [NPIX];

    assign wr_row_ok_s = ({1'b0, wr_addr[AW-1:COL_BITS]} < ROW_LIMIT);
    assign rd_row_ok_s = ({1'b0, rd_addr[AW-1:COL_BITS]} < ROW_LIMIT);

    // FSM state, mode latch and fill counter; reset parks in a pending band fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FILL;
            mode_r  <= 2'd0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ST_FILL);
        end
    end

    // Next-state logic: accept a fill only in IDLE, leave FILL after the last pixel.
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (init_start) begin
                    state_nxt_s = ST_FILL;
                    mode_nxt_s  = init_mode;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (cnt_r == LAST_PIX) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + AW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Single write port: the fill engine owns it in FILL, the host in IDLE.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_r;
        mem_wdata_s = 3'b000;
        if (state_r == ST_FILL) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = pattern_pixel(mode_r, cnt_r[AW-1:COL_BITS], cnt_r[COL_BITS-1:0]);
        end else if (wr_en && wr_row_ok_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_addr;
            mem_wdata_s = wr_data;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Pixel storage; deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Registered read port, read-first against a same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_r  <= 3'b000;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                if ((state_r == ST_FILL) || !rd_row_ok_s) begin
                    rd_data_r <= 3'b000;
                end else begin
                    rd_data_r <= mem_r[rd_addr];
                end
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign init_busy = busy_r;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;

endmodule

// File: tb/tb_vram_pattern_buffer.sv
// Directed self-checking bench for vram_pattern_buffer (default parameters).
module tb_vram_pattern_buffer;

    localparam int NPIX = 12288;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_start;
    logic [1:0]  init_mode;
    logic        init_busy;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [2:0]  wr_data;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [2:0]  rd_data;
    logic        rd_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    vram_pattern_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .init_start (init_start),
        .init_mode  (init_mode),
        .init_busy  (init_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one read at a negedge, check the result at the following negedge.
    task automatic do_read(input string tag, input int row, input int col, input logic [2:0] exp);
        rd_en   = 1'b1;
        rd_addr = {row[6:0], col[6:0]};
        @(negedge clk);
        rd_en   = 1'b0;
        check({tag, " valid"}, {31'd0, rd_valid}, 32'd1);
        check(tag, {29'd0, rd_data}, {29'd0, exp});
    endtask

    task automatic start_fill(input logic [1:0] mode);
        init_start = 1'b1;
        init_mode  = mode;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    // Count busy cycles (bounded); at cycle poke_at inject a second init_start,
    // a host write to (0,0) and a read, all of which the fill must shrug off.
    task automatic fill_wait(input string tag, input int poke_at);
        int n;
        n = 0;
        while (init_busy && n < 20000) begin
            n++;
            if (n == poke_at) begin
                init_start = 1'b1;
                init_mode  = 2'd1;
                wr_en      = 1'b1;
                wr_addr    = 14'd0;
                wr_data    = 3'b101;
                rd_en      = 1'b1;
                rd_addr    = {7'd1, 7'd1};
            end else if (n == poke_at + 1) begin
                init_start = 1'b0;
                wr_en      = 1'b0;
                rd_en      = 1'b0;
            end
            @(negedge clk);
            if (n == poke_at) begin
                check("fill read valid", {31'd0, rd_valid}, 32'd1);
                check("fill read data", {29'd0, rd_data}, 32'd0);
            end
        end
        check({tag, " busy cycles"}, n, NPIX);
    endtask

    int          b_row [8] = '{0, 23, 24, 47, 48, 71, 72, 95};
    int          b_col [8] = '{0, 0, 0, 5, 0, 127, 5, 127};
    logic [2:0]  b_exp [8] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001, 3'b111, 3'b111};

    initial begin
        reset      = 1'b1;
        init_start = 1'b0;
        init_mode  = 2'd0;
        wr_en      = 1'b0;
        wr_addr    = 14'd0;
        wr_data    = 3'b000;
        rd_en      = 1'b0;
        rd_addr    = 14'd0;

        repeat (2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("reset busy", {31'd0, init_busy}, 32'd1);
        check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset rd_data", {29'd0, rd_data}, 32'd0);

        reset = 1'b0;
        fill_wait("boot", -1);
        check("boot idle", {31'd0, init_busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_read($sformatf("band r%0d c%0d", b_row[i], b_col[i]), b_row[i], b_col[i], b_exp[i]);
        end
        @(negedge clk);
        check("rd_valid idle", {31'd0, rd_valid}, 32'd0);

        // Back-to-back reads, one per cycle.
        rd_en   = 1'b1;
        rd_addr = {7'd0, 7'd0};
        @(negedge clk);
        check("b2b first", {29'd0, rd_data}, 32'd4);
        rd_addr = {7'd24, 7'd0};
        @(negedge clk);
        rd_en = 1'b0;
        check("b2b second", {29'd0, rd_data}, 32'd2);
        check("b2b valid", {31'd0, rd_valid}, 32'd1);

        // Host write then readback.
        wr_en   = 1'b1;
        wr_addr = {7'd10, 7'd5};
        wr_data = 3'b011;
        @(negedge clk);
        wr_en = 1'b0;
        do_read("host wr", 10, 5, 3'b011);
        @(negedge clk);
        check("valid drops", {31'd0, rd_valid}, 32'd0);

        // Same-cycle write and read of one address: old pixel first.
        wr_en   = 1'b1;
        wr_data = 3'b110;
        rd_en   = 1'b1;
        rd_addr = {7'd10, 7'd5};
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rw same cycle", {29'd0, rd_data}, 32'd3);
        do_read("rw after", 10, 5, 3'b110);

        // Out-of-range row.
        wr_en   = 1'b1;
        wr_addr = {7'd100, 7'd0};
        wr_data = 3'b101;
        @(negedge clk);
        wr_en = 1'b0;
        do_read("row 100", 100, 0, 3'b000);

        // Checker fill with an ignored restart, dropped write, read during fill.
        start_fill(2'd2);
        fill_wait("checker", 100);
        do_read("chk 0,0", 0, 0, 3'b000);
        do_read("chk 0,1", 0, 1, 3'b111);
        do_read("chk 1,1", 1, 1, 3'b000);
        do_read("chk 1,0", 1, 0, 3'b111);
        do_read("chk 95,127", 95, 127, 3'b000);
        do_read("chk 10,5", 10, 5, 3'b111);

        // Bars fill aborted by reset at cycle 5000, with a read in flight.
        start_fill(2'd1);
        repeat (4999) @(negedge clk);
        check("bars busy", {31'd0, init_busy}, 32'd1);
        rd_en   = 1'b1;
        rd_addr = {7'd0, 7'd3};
        reset   = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("abort busy", {31'd0, init_busy}, 32'd1);
        check("abort rd_valid", {31'd0, rd_valid}, 32'd0);
        reset = 1'b0;
        fill_wait("refill", -1);
        do_read("refill 0,3", 0, 3, 3'b100);
        do_read("refill 50,3", 50, 3, 3'b001);
        do_read("refill 10,5", 10, 5, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
